ps2_key_event_rx: RTL

- Parametrised successor to the single-event PS/2 keyboard receiver.
- Adds an input glitch filter, odd-parity and stop-bit checking, and a frame timeout.
- Decodes the E0 (extended) and F0 (break) prefixes and queues complete key events in a FIFO with a valid/ready handshake.
- Sits between the board PS/2 pins and the game input controller, so the consumer can stall without losing keys.

---
 rtl/ps2_pkg.sv | 23 ++
 rtl/sync_fifo.sv | 61 ++++++
 rtl/ps2_key_event_rx.sv | 232 +++++++++++++++++++++++
 3 files changed

// File: rtl/ps2_pkg.sv
// ps2_pkg: shared types and constants for the PS/2 key event receiver.
//   PS2_PREFIX_EXT / PS2_PREFIX_BRK : scan-code prefixes for extended and break codes
//   ps2_state_t                     : frame FSM states
//   key_event_t                     : one queued key event {ext, make, code}
package ps2_pkg;

  localparam logic [7:0] PS2_PREFIX_EXT = 8'hE0;
  localparam logic [7:0] PS2_PREFIX_BRK = 8'hF0;

  typedef enum logic [1:0] {
    IDLE,
    DATA,
    PARITY,
    STOP
  } ps2_state_t;

  typedef struct packed {
    logic       ext;
    logic       make;
    logic [7:0] code;
  } key_event_t;

endpackage

// File: rtl/sync_fifo.sv
// sync_fifo: single-clock FIFO with a first-word-fall-through head.
//   clk, rst     : clock, asynchronous active-low reset
//   push, wdata  : write request and entry (ignored when full unless popping)
//   pop          : remove the head entry (ignored when empty)
//   rdata        : current head entry
//   full, empty  : occupancy flags
module sync_fifo #(
  parameter int WIDTH = 10,
  parameter int DEPTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  input  logic             pop,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW:0]      count;
  logic             wr_en;
  logic             rd_en;

  // A pop frees the slot in the same cycle, so a push into a full FIFO
  // may proceed when it coincides with a pop.
  assign wr_en = push && (!full || pop);
  assign rd_en = pop && !empty;
  assign full  = (count == (AW+1)'(DEPTH));
  assign empty = (count == '0);
  assign rdata = mem[rd_ptr];

  // NOTE: storage has no reset; only pointers and count define validity,
  // which keeps the array as plain RAM.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr] <= wdata;
  end

  // Power-of-two depth: pointers wrap naturally on overflow of their width.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + AW'(1);
      if (rd_en) rd_ptr <= rd_ptr + AW'(1);
      case ({wr_en, rd_en})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/ps2_key_event_rx.sv
// ps2_key_event_rx: PS/2 keyboard receiver producing queued key events.
//   clk, rst          : system clock, asynchronous active-low reset
//   ps2_clk, ps2_data : raw asynchronous PS/2 pins
//   evt_valid/ready   : handshake for the FIFO head event
//   evt_code/make/ext : head scan code, press(1)/release(0), E0-prefixed
//   parity_err        : pulse on parity or stop-bit failure
//   timeout_err       : pulse when a frame stalls mid-way
//   overflow          : pulse when an event is dropped on a full FIFO
//   err_count         : saturating count of parity/stop/timeout errors
module ps2_key_event_rx
  import ps2_pkg::*;
#(
  parameter int FILTER_LEN     = 8,
  parameter int TIMEOUT_CYCLES = 200000,
  parameter int FIFO_DEPTH     = 8,
  parameter int ERR_CNT_W      = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 ps2_clk,
  input  logic                 ps2_data,
  output logic                 evt_valid,
  input  logic                 evt_ready,
  output logic [7:0]           evt_code,
  output logic                 evt_make,
  output logic                 evt_ext,
  output logic                 parity_err,
  output logic                 timeout_err,
  output logic                 overflow,
  output logic [ERR_CNT_W-1:0] err_count
);

  localparam int FCW = $clog2(FILTER_LEN + 1);
  localparam int TCW = $clog2(TIMEOUT_CYCLES + 1);

  // Input synchronisers and glitch filter
  logic           clk_s1, clk_s2, dat_s1, dat_s2;
  logic           filt_clk, filt_clk_d;
  logic [FCW-1:0] filt_cnt;
  logic           strobe;

  // NOTE: sequential state always uses non-blocking assignments so every
  // register samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      clk_s1     <= 1'b1;
      clk_s2     <= 1'b1;
      dat_s1     <= 1'b1;
      dat_s2     <= 1'b1;
      filt_clk   <= 1'b1;
      filt_clk_d <= 1'b1;
      filt_cnt   <= '0;
    end else begin
      clk_s1     <= ps2_clk;
      clk_s2     <= clk_s1;
      dat_s1     <= ps2_data;
      dat_s2     <= dat_s1;
      filt_clk_d <= filt_clk;
      // Any sample matching the current level restarts the run count.
      if (clk_s2 != filt_clk) begin
        if (filt_cnt == FCW'(FILTER_LEN - 1)) begin
          filt_clk <= clk_s2;
          filt_cnt <= '0;
        end else begin
          filt_cnt <= filt_cnt + FCW'(1);
        end
      end else begin
        filt_cnt <= '0;
      end
    end
  end

  assign strobe = filt_clk_d & ~filt_clk;

  // Frame FSM
  ps2_state_t     state_q, state_d;
  logic [2:0]     bit_idx_q, bit_idx_d;
  logic [7:0]     shift_q, shift_d;
  logic           par_q, par_d;
  logic [TCW-1:0] idle_cnt_q, idle_cnt_d;
  logic [7:0]     byte_q, byte_d;
  logic           byte_vld_q, byte_vld_d;
  logic           par_err_d, to_err_d;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      bit_idx_q   <= '0;
      shift_q     <= '0;
      par_q       <= 1'b0;
      idle_cnt_q  <= '0;
      byte_q      <= '0;
      byte_vld_q  <= 1'b0;
      parity_err  <= 1'b0;
      timeout_err <= 1'b0;
    end else begin
      state_q     <= state_d;
      bit_idx_q   <= bit_idx_d;
      shift_q     <= shift_d;
      par_q       <= par_d;
      idle_cnt_q  <= idle_cnt_d;
      byte_q      <= byte_d;
      byte_vld_q  <= byte_vld_d;
      parity_err  <= par_err_d;
      timeout_err <= to_err_d;
    end
  end

  // NOTE: every signal driven here gets a default first, so no path can
  // leave one unassigned and infer a latch.
  always_comb begin
    state_d    = state_q;
    bit_idx_d  = bit_idx_q;
    shift_d    = shift_q;
    par_d      = par_q;
    idle_cnt_d = '0;
    byte_d     = byte_q;
    byte_vld_d = 1'b0;
    par_err_d  = 1'b0;
    to_err_d   = 1'b0;

    if (state_q != IDLE) idle_cnt_d = idle_cnt_q + TCW'(1);

    if (strobe) begin
      idle_cnt_d = '0;
      case (state_q)
        IDLE: begin
          if (!dat_s2) begin
            state_d   = DATA;
            bit_idx_d = '0;
          end
        end
        DATA: begin
          shift_d   = {dat_s2, shift_q[7:1]};
          bit_idx_d = bit_idx_q + 3'd1;
          if (bit_idx_q == 3'd7) state_d = PARITY;
        end
        PARITY: begin
          par_d   = dat_s2;
          state_d = STOP;
        end
        STOP: begin
          // Odd parity over data+parity, and the stop bit must be high.
          if ((^{shift_q, par_q}) && dat_s2) begin
            byte_vld_d = 1'b1;
            byte_d     = shift_q;
          end else begin
            par_err_d = 1'b1;
          end
          state_d = IDLE;
        end
        default: state_d = IDLE;
      endcase
    end else if (state_q != IDLE && idle_cnt_q == TCW'(TIMEOUT_CYCLES - 1)) begin
      to_err_d = 1'b1;
      state_d  = IDLE;
    end
  end

  // Prefix decoder
  logic       ext_flag, brk_flag;
  logic       push_q;
  key_event_t push_evt;
  key_event_t head;
  logic       fifo_full, fifo_empty, pop;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ext_flag <= 1'b0;
      brk_flag <= 1'b0;
      push_q   <= 1'b0;
      push_evt <= '0;
    end else begin
      push_q <= 1'b0;
      if (byte_vld_q) begin
        case (byte_q)
          PS2_PREFIX_EXT: ext_flag <= 1'b1;
          PS2_PREFIX_BRK: brk_flag <= 1'b1;
          default: begin
            push_q        <= 1'b1;
            push_evt.ext  <= ext_flag;
            push_evt.make <= ~brk_flag;
            push_evt.code <= byte_q;
            ext_flag      <= 1'b0;
            brk_flag      <= 1'b0;
          end
        endcase
      end
      // A corrupted or abandoned byte may have been the one completing a
      // prefixed sequence, so stale prefixes must not leak into the next key.
      if (parity_err || timeout_err) begin
        ext_flag <= 1'b0;
        brk_flag <= 1'b0;
      end
    end
  end

  assign pop = evt_valid && evt_ready;

  sync_fifo #(
    .WIDTH ($bits(key_event_t)),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push_q),
    .wdata (push_evt),
    .pop   (pop),
    .rdata (head),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  // Head fields are forced to zero while empty so uninitialised storage
  // never reaches the outputs.
  assign evt_valid = ~fifo_empty;
  assign evt_code  = evt_valid ? head.code : 8'h00;
  assign evt_make  = evt_valid ? head.make : 1'b0;
  assign evt_ext   = evt_valid ? head.ext  : 1'b0;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      overflow  <= 1'b0;
      err_count <= '0;
    end else begin
      overflow <= push_q && fifo_full && !pop;
      if ((parity_err || timeout_err) && err_count != '1)
        err_count <= err_count + ERR_CNT_W'(1);
    end
  end

endmodule
